// File: rtl/s_extend_pkg.sv
// Shared widths for the decode and ALU blocks.
// Also carries the immediate-extension mode select.
package s_extend_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

endpackage

// File: rtl/s_extend_ext_core.sv
// Combinational widener for the immediate field.
// Fills the upper bits with the MSB in sign mode, and with zeros otherwise.
module ext_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in,
  input  logic             sign_mode,
  output logic [OUT_W-1:0] out
);

  logic fill;

  assign fill = sign_mode & in[IN_W-1];
  assign out  = {{(OUT_W-IN_W){fill}}, in};

endmodule

// File: rtl/s_extend.sv
// ID-stage immediate extender.
// Produces sign, zero and branch-offset forms, plus an ID/EX register.
module s_extend
  import s_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  nextend,
  output logic [OUT_W-1:0] extend,
  output logic [OUT_W-1:0] extend_zero,
  output logic [OUT_W-1:0] extend_sl2,
  output logic             is_neg,
  output logic [OUT_W-1:0] extend_q,
  output logic [OUT_W-1:0] extend_sl2_q
);

  generate
    if (OUT_W <= IN_W + 2) begin : g_bad_w
      $error("s_extend: OUT_W must exceed IN_W + 2");
    end
  endgenerate

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sign (
    .in        (nextend),
    .sign_mode (EXT_SIGN),
    .out       (extend)
  );

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_zero (
    .in        (nextend),
    .sign_mode (EXT_ZERO),
    .out       (extend_zero)
  );

  // Top two bits are dropped; branch range is the caller's problem.
  assign extend_sl2 = {extend[OUT_W-3:0], 2'b00};
  assign is_neg     = nextend[IN_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      extend_q     <= '0;
      extend_sl2_q <= '0;
    end else begin
      extend_q     <= extend;
      extend_sl2_q <= extend_sl2;
    end
  end

endmodule

// File: tb/tb_s_extend.sv
// Scoreboard bench for s_extend.
// The model is arithmetic sign/zero extension.
module tb_s_extend;

  logic        clk;
  logic        rst;
  logic [15:0] nextend;
  logic [31:0] extend;
  logic [31:0] extend_zero;
  logic [31:0] extend_sl2;
  logic        is_neg;
  logic [31:0] extend_q;
  logic [31:0] extend_sl2_q;

  typedef struct {
    logic [15:0] v;
    logic [31:0] ext;
    logic [31:0] zero;
    logic [31:0] sl2;
    logic        neg;
    logic [31:0] q;
    logic [31:0] sl2q;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  s_extend dut (
    .clk          (clk),
    .rst          (rst),
    .nextend      (nextend),
    .extend       (extend),
    .extend_zero  (extend_zero),
    .extend_sl2   (extend_sl2),
    .is_neg       (is_neg),
    .extend_q     (extend_q),
    .extend_sl2_q (extend_sl2_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_sext(input logic [15:0] v);
    int s;
    s = $signed(v);
    return 32'(s);
  endfunction

  function automatic logic [31:0] m_zext(input logic [15:0] v);
    int unsigned u;
    u = v;
    return 32'(u);
  endfunction

  function automatic logic [31:0] m_sl2(input logic [15:0] v);
    longint s;
    s = $signed(v);
    s = s * 4;
    return s[31:0];
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("extend",       extend,       e.ext);
      chk("extend_zero",  extend_zero,  e.zero);
      chk("extend_sl2",   extend_sl2,   e.sl2);
      chk("is_neg",       32'(is_neg),  32'(e.neg));
      chk("extend_q",     extend_q,     e.q);
      chk("extend_sl2_q", extend_sl2_q, e.sl2q);
    end
  end

  logic [15:0] dir [6];
  logic [15:0] prev;

  task automatic drive(input logic [15:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    nextend = v;
    e.v    = v;
    e.ext  = m_sext(v);
    e.zero = m_zext(v);
    e.sl2  = m_sl2(v);
    e.neg  = ($signed(v) < 0);
    e.q    = m_sext(prev);
    e.sl2q = m_sl2(prev);
    sbq.push_back(e);
    prev = v;
  endtask

  initial begin
    dir[0] = 16'h0000;
    dir[1] = 16'h0013;
    dir[2] = 16'h801B;
    dir[3] = 16'h7FFF;
    dir[4] = 16'h8000;
    dir[5] = 16'hFFFF;

    rst     = 1'b1;
    nextend = 16'h0000;
    prev    = 16'h0000;
    #1;
    chk("rst_q",     extend_q,     32'h0);
    chk("rst_sl2q",  extend_sl2_q, 32'h0);
    nextend = 16'h8000;
    #1;
    chk("rst_comb",  extend,       32'hFFFF8000);
    nextend = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) drive(dir[i]);
    for (int k = 0; k < 1000; k++) begin
      drive(16'($urandom));
    end

    drive(16'h801B);
    @(posedge clk);
    #1;
    chk("pre_rst_q", extend_q, 32'hFFFF801B);
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_q",    extend_q,     32'h0);
    chk("mid_rst_sl2q", extend_sl2_q, 32'h0);
    chk("mid_rst_ext",  extend,       32'hFFFF801B);
    chk("mid_rst_sl2",  extend_sl2,   32'hFFFE006C);
    @(posedge clk);
    #1;
    chk("hold_rst_q", extend_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_q", extend_q, 32'h0);
    @(posedge clk);
    #1;
    chk("cap_q",    extend_q,     32'hFFFF801B);
    chk("cap_sl2q", extend_sl2_q, 32'hFFFE006C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
